// File: rtl/core_mem_responder_pkg.sv
// Shared types and lane helpers for the core's memory-side transfer responder.
package core_mem_responder_pkg;

  // Transfer size as carried on the core's size field; 3 is not a legal size.
  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2,
    MEM_BAD  = 2'd3
  } mem_size_t;

  // Responder control states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RESP    = 2'd3
  } mem_state_t;

  // Byte lanes touched by an access of the given size at the given byte offset.
  function automatic logic [3:0] mem_lane_enable(input mem_size_t size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      MEM_BYTE: be = 4'b0001 << addr_lo;
      MEM_HALF: be = 4'b0011 << addr_lo;
      MEM_WORD: be = 4'b1111;
      default:  be = 4'b0000;
    endcase
    return be;
  endfunction

  // True when the access is not naturally aligned or the size is illegal.
  function automatic logic mem_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      MEM_BYTE: bad = 1'b0;
      MEM_HALF: bad = addr_lo[0];
      MEM_WORD: bad = |addr_lo;
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/core_mem_lanes.sv
// Combinational lane steering: byte enables and store replication for the
// outgoing request, and right-justify/zero-extend for returning load data.
module core_mem_lanes
  import core_mem_responder_pkg::*;
(
  input  mem_size_t   size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data_wr,
  input  mem_size_t   rd_size,
  input  logic [1:0]  rd_addr_lo,
  input  logic [31:0] readdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] rd_data
);

  logic [31:0] shifted_s;

  // Store side: lane enables and data replicated so every lane carries the operand.
  always_comb begin
    byteenable = mem_lane_enable(size, addr_lo);
    case (size)
      MEM_BYTE: writedata = {4{data_wr[7:0]}};
      MEM_HALF: writedata = {2{data_wr[15:0]}};
      MEM_WORD: writedata = data_wr;
      default:  writedata = 32'h0000_0000;
    endcase
  end

  // Load side: bring the addressed lane down to bit 0 and clear everything above the size.
  always_comb begin
    shifted_s = readdata >> {rd_addr_lo, 3'b000};
    case (rd_size)
      MEM_BYTE: rd_data = {24'h00_0000, shifted_s[7:0]};
      MEM_HALF: rd_data = {16'h0000, shifted_s[15:0]};
      MEM_WORD: rd_data = shifted_s;
      default:  rd_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/core_mem_responder.sv
// Memory-side end of the core load/store handshake, mastering an Avalon-MM bus.
// One request at a time; answers with a single-cycle mem_ready (plus mem_fault).
module core_mem_responder
  import core_mem_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] LIMIT_ADDR = 32'h3FFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        write,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] data_wr,
  output logic        mem_ready,
  output logic        mem_fault,
  output logic [31:0] data_rd,
  output logic        busy,
  output logic [29:0] avl_address,
  output logic        avl_read,
  output logic        avl_write,
  output logic [3:0]  avl_byteenable,
  output logic [31:0] avl_writedata,
  input  logic        avl_waitrequest,
  input  logic [31:0] avl_readdata,
  input  logic        avl_readdatavalid
);

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
  localparam logic [31:0] ADDR_SPAN   = LIMIT_ADDR - BASE_ADDR;

  mem_state_t  state_r, state_s;
  logic        fault_r, fault_s;
  logic        write_r;
  mem_size_t   size_r;
  logic [1:0]  addr_lo_r;
  logic [15:0] cnt_r, cnt_s;

  mem_size_t   req_size_s;
  logic        illegal_s;
  logic        latch_s;
  logic        rd_s, wr_s, ready_s, mfault_s, busy_s;
  logic [31:0] data_rd_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s, rd_data_s;

  core_mem_lanes u_lanes (
    .size       (req_size_s),
    .addr_lo    (addr[1:0]),
    .data_wr    (data_wr),
    .rd_size    (size_r),
    .rd_addr_lo (addr_lo_r),
    .readdata   (avl_readdata),
    .byteenable (be_s),
    .writedata  (wdata_s),
    .rd_data    (rd_data_s)
  );

  // Request legality: alignment, size and the unsigned window [BASE_ADDR, LIMIT_ADDR].
  always_comb begin
    req_size_s = mem_size_t'(size);
    illegal_s  = mem_misaligned(req_size_s, addr[1:0]) | ((addr - BASE_ADDR) > ADDR_SPAN);
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_s   = state_r;
    fault_s   = fault_r;
    cnt_s     = cnt_r;
    data_rd_s = data_rd;
    latch_s   = 1'b0;
    rd_s      = 1'b0;
    wr_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          // Illegal requests still pass through one strobe-less REQ cycle so the
          // fault answer arrives with the same latency as a zero-wait store.
          latch_s = 1'b1;
          cnt_s   = 16'd0;
          fault_s = illegal_s;
          rd_s    = ~illegal_s & ~write;
          wr_s    = ~illegal_s & write;
          state_s = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        cnt_s = cnt_r + 16'd1;
        if (fault_r) begin
          state_s = ST_RESP;
        end else if (!avl_waitrequest) begin
          state_s = write_r ? ST_RESP : ST_RD_WAIT;
        end else if (cnt_s == TIMEOUT_CNT) begin
          fault_s = 1'b1;
          state_s = ST_RESP;
        end else begin
          rd_s = avl_read;
          wr_s = avl_write;
        end
      end
      ST_RD_WAIT: begin
        cnt_s = cnt_r + 16'd1;
        if (avl_readdatavalid) begin
          data_rd_s = rd_data_s;
          state_s   = ST_RESP;
        end else if (cnt_s == TIMEOUT_CNT) begin
          fault_s = 1'b1;
          state_s = ST_RESP;
        end else begin
          state_s = ST_RD_WAIT;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    ready_s  = (state_s == ST_RESP);
    mfault_s = (state_s == ST_RESP) & fault_s;
    busy_s   = (state_s != ST_IDLE);
  end

  // State, request latches and all outputs; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      fault_r        <= 1'b0;
      write_r        <= 1'b0;
      size_r         <= MEM_BYTE;
      addr_lo_r      <= 2'd0;
      cnt_r          <= 16'd0;
      mem_ready      <= 1'b0;
      mem_fault      <= 1'b0;
      data_rd        <= 32'h0000_0000;
      busy           <= 1'b0;
      avl_address    <= 30'd0;
      avl_read       <= 1'b0;
      avl_write      <= 1'b0;
      avl_byteenable <= 4'h0;
      avl_writedata  <= 32'h0000_0000;
    end else begin
      state_r   <= state_s;
      fault_r   <= fault_s;
      cnt_r     <= cnt_s;
      mem_ready <= ready_s;
      mem_fault <= mfault_s;
      data_rd   <= data_rd_s;
      busy      <= busy_s;
      avl_read  <= rd_s;
      avl_write <= wr_s;
      if (latch_s) begin
        write_r        <= write;
        size_r         <= req_size_s;
        addr_lo_r      <= addr[1:0];
        avl_address    <= addr[31:2];
        avl_byteenable <= illegal_s ? 4'h0 : be_s;
        avl_writedata  <= wdata_s;
      end else begin
        write_r        <= write_r;
        size_r         <= size_r;
        addr_lo_r      <= addr_lo_r;
        avl_address    <= avl_address;
        avl_byteenable <= avl_byteenable;
        avl_writedata  <= avl_writedata;
      end
    end
  end

endmodule

// File: tb/tb_core_mem_responder.sv
// Scoreboard bench for core_mem_responder: stimulus pushes the expected
// response (fault, data_rd, cycle of the ready pulse); a monitor pops and
// compares whenever mem_ready is seen.
module tb_core_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        write;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] data_wr;
  logic        mem_ready;
  logic        mem_fault;
  logic [31:0] data_rd;
  logic        busy;
  logic [29:0] avl_address;
  logic        avl_read;
  logic        avl_write;
  logic [3:0]  avl_byteenable;
  logic [31:0] avl_writedata;
  logic        avl_waitrequest;
  logic [31:0] avl_readdata;
  logic        avl_readdatavalid;

  typedef struct {
    logic        f;
    logic [31:0] d;
    int          cy;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          cyc;
  int          n_chk;
  int          n_fail;
  int          c0;
  logic [31:0] exp_data_rd;

  core_mem_responder #(
    .TIMEOUT    (8),
    .BASE_ADDR  (32'h0000_0000),
    .LIMIT_ADDR (32'h3FFF_FFFF)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .write             (write),
    .size              (size),
    .addr              (addr),
    .data_wr           (data_wr),
    .mem_ready         (mem_ready),
    .mem_fault         (mem_fault),
    .data_rd           (data_rd),
    .busy              (busy),
    .avl_address       (avl_address),
    .avl_read          (avl_read),
    .avl_write         (avl_write),
    .avl_byteenable    (avl_byteenable),
    .avl_writedata     (avl_writedata),
    .avl_waitrequest   (avl_waitrequest),
    .avl_readdata      (avl_readdata),
    .avl_readdatavalid (avl_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising-edge counter used to time ready pulses.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (mem_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ready: got ready at cycle %0d expected none", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ready_cycle", cyc, mon_e.cy);
        chk("mem_fault", {31'd0, mem_fault}, {31'd0, mon_e.f});
        chk("data_rd", data_rd, mon_e.d);
      end
    end else begin
      chk("fault_without_ready", {31'd0, mem_fault}, 32'd0);
    end
  end

  // Start one request at a negedge; returns at the following negedge with start low.
  task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input logic exp_f, input logic [31:0] exp_d,
                       input int lat);
    @(negedge clk);
    chk("start_in_idle", {31'd0, busy}, 32'd0);
    write   = w;
    size    = sz;
    addr    = a;
    data_wr = d;
    start   = 1'b1;
    c0      = cyc;
    exp_q.push_back('{f: exp_f, d: exp_d, cy: c0 + lat});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (!busy && !mem_ready) break;
      @(negedge clk);
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    cyc = 0; n_chk = 0; n_fail = 0; c0 = 0;
    rst_n = 1'b0; start = 1'b0; write = 1'b0; size = 2'd0;
    addr = 32'd0; data_wr = 32'd0;
    avl_waitrequest = 1'b0; avl_readdata = 32'd0; avl_readdatavalid = 1'b0;
    exp_data_rd = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_read", {31'd0, avl_read}, 32'd0);
    chk("rst_write", {31'd0, avl_write}, 32'd0);
    chk("rst_data_rd", data_rd, 32'd0);
    chk("rst_be", {28'd0, avl_byteenable}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: word store, zero wait
    issue(1'b1, 2'd2, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, exp_data_rd, 2);
    chk("t1_write", {31'd0, avl_write}, 32'd1);
    chk("t1_read", {31'd0, avl_read}, 32'd0);
    chk("t1_address", {2'd0, avl_address}, 32'h0000_0040);
    chk("t1_be", {28'd0, avl_byteenable}, 32'h0000_000F);
    chk("t1_wdata", avl_writedata, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t1_write_drop", {31'd0, avl_write}, 32'd0);
    wait_idle();

    // 2: byte load at 0x103, data valid two cycles after accept
    exp_data_rd = 32'h0000_00AA;
    issue(1'b0, 2'd0, 32'h0000_0103, 32'd0, 1'b0, exp_data_rd, 4);
    chk("t2_read", {31'd0, avl_read}, 32'd1);
    chk("t2_be", {28'd0, avl_byteenable}, 32'h0000_0008);
    chk("t2_address", {2'd0, avl_address}, 32'h0000_0040);
    @(negedge clk);
    chk("t2_read_drop", {31'd0, avl_read}, 32'd0);
    @(negedge clk);
    avl_readdata = 32'hAABB_CCDD; avl_readdatavalid = 1'b1;
    @(negedge clk);
    avl_readdatavalid = 1'b0;
    wait_idle();

    // Half load at 0x002, valid one cycle after accept
    exp_data_rd = 32'h0000_1122;
    issue(1'b0, 2'd1, 32'h0000_0002, 32'd0, 1'b0, exp_data_rd, 3);
    chk("hl_be", {28'd0, avl_byteenable}, 32'h0000_000C);
    @(negedge clk);
    avl_readdata = 32'h1122_3344; avl_readdatavalid = 1'b1;
    @(negedge clk);
    avl_readdatavalid = 1'b0;
    wait_idle();

    // 3: misaligned half store, out-of-range half store, illegal size
    issue(1'b1, 2'd1, 32'h0000_0101, 32'h0000_5555, 1'b1, exp_data_rd, 2);
    chk("t3a_nostrobe", {30'd0, avl_read, avl_write}, 32'd0);
    @(negedge clk);
    chk("t3a_nostrobe2", {30'd0, avl_read, avl_write}, 32'd0);
    wait_idle();
    issue(1'b1, 2'd1, 32'h4000_0000, 32'h0000_5555, 1'b1, exp_data_rd, 2);
    chk("t3b_nostrobe", {30'd0, avl_read, avl_write}, 32'd0);
    @(negedge clk);
    chk("t3b_nostrobe2", {30'd0, avl_read, avl_write}, 32'd0);
    wait_idle();
    issue(1'b0, 2'd3, 32'h0000_0000, 32'd0, 1'b1, exp_data_rd, 2);
    chk("t3c_nostrobe", {30'd0, avl_read, avl_write}, 32'd0);
    wait_idle();

    // 4: half store at 0x20A with waitrequest held three cycles
    avl_waitrequest = 1'b1;
    issue(1'b1, 2'd1, 32'h0000_020A, 32'h1234_5678, 1'b0, exp_data_rd, 5);
    for (int i = 0; i < 4; i++) begin
      chk("t4_write", {31'd0, avl_write}, 32'd1);
      chk("t4_address", {2'd0, avl_address}, 32'h0000_0082);
      chk("t4_be", {28'd0, avl_byteenable}, 32'h0000_000C);
      chk("t4_wdata", avl_writedata, 32'h5678_5678);
      if (i == 3) avl_waitrequest = 1'b0;
      @(negedge clk);
    end
    chk("t4_write_drop", {31'd0, avl_write}, 32'd0);
    wait_idle();

    // 5: timeout (TIMEOUT=8) on a word load, then late readdatavalid
    avl_waitrequest = 1'b1;
    issue(1'b0, 2'd2, 32'h0000_0300, 32'd0, 1'b1, exp_data_rd, 9);
    for (int i = 0; i < 8; i++) begin
      chk("t5_read_held", {31'd0, avl_read}, 32'd1);
      @(negedge clk);
    end
    chk("t5_read_drop", {31'd0, avl_read}, 32'd0);
    avl_waitrequest = 1'b0;
    @(negedge clk);
    avl_readdata = 32'h1234_5678; avl_readdatavalid = 1'b1;
    @(negedge clk);
    avl_readdatavalid = 1'b0;
    chk("t5_late_data_rd", data_rd, exp_data_rd);
    chk("t5_late_busy", {31'd0, busy}, 32'd0);
    wait_idle();

    // 6: reset while waiting for read data, then a normal load
    issue(1'b0, 2'd2, 32'h0000_0400, 32'd0, 1'b0, exp_data_rd, 3);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_read", {31'd0, avl_read}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_data_rd", data_rd, 32'd0);
    chk("t6_ready", {31'd0, mem_ready}, 32'd0);
    exp_data_rd = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_data_rd = 32'hCAFE_F00D;
    issue(1'b0, 2'd2, 32'h0000_0404, 32'd0, 1'b0, exp_data_rd, 3);
    chk("t6b_address", {2'd0, avl_address}, 32'h0000_0101);
    @(negedge clk);
    avl_readdata = 32'hCAFE_F00D; avl_readdatavalid = 1'b1;
    @(negedge clk);
    avl_readdatavalid = 1'b0;
    wait_idle();

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
